jcontrol_seq: RTL and testbench

Control-signal sequencer: the consumer end of the clock/stepper timing interface. It samples the `jclock` enable/set windows (`wclke`, `wclks`) and the `jstepper` one-hot step vector (`bos`). From these, the instruction register and the latched ALU flags, it produces registered bus-enable and register-set strobes for the 8-bit CPU datapath. It also polices the step sequence and counts completed instructions.

---
 rtl/jcontrol_seq.sv | 176 +++++++++++++++++
 tb/tb_jcontrol_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jcontrol_seq.sv
// Control-signal sequencer: decodes stepper position, instruction and flags into
// registered bus-enable / register-set strobes, and polices the step sequence.
module jcontrol_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wclke,
    input  logic             wclks,
    input  logic [0:5]       bos,
    input  logic [7:0]       ir,
    input  logic [3:0]       flags,
    output logic             en_bus1,
    output logic             en_iar,
    output logic             en_ram,
    output logic             en_acc,
    output logic [0:3]       en_reg,
    output logic             s_mar,
    output logic             s_acc,
    output logic             s_ir,
    output logic             s_iar,
    output logic             s_ram,
    output logic             s_tmp,
    output logic             s_flags,
    output logic [0:3]       s_reg,
    output logic [2:0]       alu_op,
    output logic             step_err,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        ST_NONE = 3'd0, ST_1 = 3'd1, ST_2 = 3'd2, ST_3 = 3'd3,
        ST_4 = 3'd4, ST_5 = 3'd5, ST_6 = 3'd6
    } step_e;

    step_e            cur, prev_d, prev_q;
    logic [1:0]       ra, rb;
    logic             d_bus1, d_iar, d_ram, d_acc;
    logic [0:3]       d_reg;
    logic             d_mar, d_sacc, d_ir, d_siar, d_sram, d_tmp, d_flags;
    logic [0:3]       d_sreg;
    logic [2:0]       d_op;
    logic [7:0]       en_d, en_q;
    logic [10:0]      set_d, set_q;
    logic [2:0]       op_d, op_q;
    logic             err_now, wrap_ok, step_err_d, step_err_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Successor of "none" is step 1, which makes a clean restart the only legal move.
    function automatic step_e succ(input step_e s);
        case (s)
            ST_1:    return ST_2;
            ST_2:    return ST_3;
            ST_3:    return ST_4;
            ST_4:    return ST_5;
            ST_5:    return ST_6;
            default: return ST_1;
        endcase
    endfunction

    assign ra = ir[3:2];
    assign rb = ir[1:0];

    always_comb begin
        case (bos)
            6'b100000: cur = ST_1;
            6'b010000: cur = ST_2;
            6'b001000: cur = ST_3;
            6'b000100: cur = ST_4;
            6'b000010: cur = ST_5;
            6'b000001: cur = ST_6;
            default:   cur = ST_NONE;
        endcase
    end

    always_comb begin
        err_now = 1'b0;
        wrap_ok = 1'b0;
        prev_d  = prev_q;
        if (cur == ST_NONE) begin
            err_now = wclke;
        end else if (cur != prev_q) begin
            if (cur != succ(prev_q)) begin
                err_now = 1'b1;
            end else begin
                prev_d  = cur;
                wrap_ok = (prev_q == ST_6);
            end
        end
        if (err_now) prev_d = ST_NONE;
        step_err_d = step_err_q | err_now;
        cnt_d      = cnt_q + CNT_W'(wrap_ok);
    end

    always_comb begin
        d_bus1 = 1'b0; d_iar = 1'b0; d_ram = 1'b0; d_acc = 1'b0; d_reg = '0;
        d_mar = 1'b0; d_sacc = 1'b0; d_ir = 1'b0; d_siar = 1'b0; d_sram = 1'b0;
        d_tmp = 1'b0; d_flags = 1'b0; d_sreg = '0; d_op = '0;
        case (cur)
            ST_1: begin d_bus1 = 1'b1; d_iar = 1'b1; d_mar = 1'b1; d_sacc = 1'b1; end
            ST_2: begin d_ram = 1'b1; d_ir = 1'b1; end
            ST_3: begin d_acc = 1'b1; d_siar = 1'b1; end
            ST_4: begin
                if (ir[7]) begin
                    d_reg[rb] = 1'b1; d_tmp = 1'b1;
                end else begin
                    case (ir[6:4])
                        3'd0, 3'd1: begin d_reg[ra] = 1'b1; d_mar = 1'b1; end
                        3'd2, 3'd5: begin d_bus1 = 1'b1; d_iar = 1'b1; d_mar = 1'b1; d_sacc = 1'b1; end
                        3'd3:       begin d_reg[rb] = 1'b1; d_siar = 1'b1; end
                        3'd4:       begin d_iar = 1'b1; d_mar = 1'b1; end
                        3'd6:       begin d_bus1 = 1'b1; d_flags = 1'b1; end
                        default:    ;
                    endcase
                end
            end
            ST_5: begin
                if (ir[7]) begin
                    d_reg[ra] = 1'b1; d_op = ir[6:4]; d_sacc = 1'b1; d_flags = 1'b1;
                end else begin
                    case (ir[6:4])
                        3'd0, 3'd2: begin d_ram = 1'b1; d_sreg[rb] = 1'b1; end
                        3'd1:       begin d_reg[rb] = 1'b1; d_sram = 1'b1; end
                        3'd4:       begin d_ram = 1'b1; d_siar = 1'b1; end
                        3'd5:       begin d_acc = 1'b1; d_siar = 1'b1; end
                        default:    ;
                    endcase
                end
            end
            ST_6: begin
                if (ir[7]) begin
                    // CMP only updates flags; the result is discarded.
                    if (ir[6:4] != 3'b111) begin d_acc = 1'b1; d_sreg[rb] = 1'b1; end
                end else if (ir[6:4] == 3'd2) begin
                    d_acc = 1'b1; d_siar = 1'b1;
                end else if (ir[6:4] == 3'd5 && (ir[3:0] & flags) != 4'b0) begin
                    d_ram = 1'b1; d_siar = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Gate with the next error state so the cycle that detects an error is already silent.
    always_comb begin
        en_d  = (wclke && !step_err_d) ? {d_bus1, d_iar, d_ram, d_acc, d_reg} : '0;
        set_d = (wclks && !step_err_d)
              ? {d_mar, d_sacc, d_ir, d_siar, d_sram, d_tmp, d_flags, d_sreg} : '0;
        op_d  = (wclke && !step_err_d) ? d_op : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q       <= '0;
            set_q      <= '0;
            op_q       <= '0;
            step_err_q <= 1'b0;
            cnt_q      <= '0;
            prev_q     <= ST_NONE;
        end else begin
            en_q       <= en_d;
            set_q      <= set_d;
            op_q       <= op_d;
            step_err_q <= step_err_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
        end
    end

    assign {en_bus1, en_iar, en_ram, en_acc, en_reg} = en_q;
    assign {s_mar, s_acc, s_ir, s_iar, s_ram, s_tmp, s_flags, s_reg} = set_q;
    assign alu_op    = op_q;
    assign step_err  = step_err_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_jcontrol_seq.sv
// Directed bench for jcontrol_seq: per-step window checks for several instruction
// classes, step-sequence errors, asynchronous reset and counter wrap.
module tb_jcontrol_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wclke = 1'b0;
    logic        wclks = 1'b0;
    logic [0:5]  bos = '0;
    logic [7:0]  ir = '0;
    logic [3:0]  flags = '0;

    logic        en_bus1, en_iar, en_ram, en_acc;
    logic [0:3]  en_reg, s_reg;
    logic        s_mar, s_acc, s_ir, s_iar, s_ram, s_tmp, s_flags;
    logic [2:0]  alu_op;
    logic        step_err;
    logic [15:0] instr_cnt;

    logic        en_bus1_4, en_iar_4, en_ram_4, en_acc_4;
    logic [0:3]  en_reg_4, s_reg_4;
    logic        s_mar_4, s_acc_4, s_ir_4, s_iar_4, s_ram_4, s_tmp_4, s_flags_4;
    logic [2:0]  alu_op_4;
    logic        step_err_4;
    logic [3:0]  instr_cnt_4;

    logic [21:0] obs;
    int checks = 0;
    int fails  = 0;

    // Packed view: {alu_op, en_bus1, en_iar, en_ram, en_acc, en_reg[0:3],
    //               s_mar, s_acc, s_ir, s_iar, s_ram, s_tmp, s_flags, s_reg[0:3]}
    assign obs = {alu_op, en_bus1, en_iar, en_ram, en_acc, en_reg,
                  s_mar, s_acc, s_ir, s_iar, s_ram, s_tmp, s_flags, s_reg};

    localparam logic [7:0]  E_S1 = 8'b1100_0000;
    localparam logic [10:0] S_S1 = 11'b110_0000_0000;
    localparam logic [7:0]  E_S2 = 8'b0010_0000;
    localparam logic [10:0] S_S2 = 11'b001_0000_0000;
    localparam logic [7:0]  E_S3 = 8'b0001_0000;
    localparam logic [10:0] S_S3 = 11'b000_1000_0000;

    jcontrol_seq #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .wclke(wclke), .wclks(wclks), .bos(bos), .ir(ir),
        .flags(flags), .en_bus1(en_bus1), .en_iar(en_iar), .en_ram(en_ram),
        .en_acc(en_acc), .en_reg(en_reg), .s_mar(s_mar), .s_acc(s_acc), .s_ir(s_ir),
        .s_iar(s_iar), .s_ram(s_ram), .s_tmp(s_tmp), .s_flags(s_flags), .s_reg(s_reg),
        .alu_op(alu_op), .step_err(step_err), .instr_cnt(instr_cnt)
    );

    jcontrol_seq #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .wclke(wclke), .wclks(wclks), .bos(bos), .ir(ir),
        .flags(flags), .en_bus1(en_bus1_4), .en_iar(en_iar_4), .en_ram(en_ram_4),
        .en_acc(en_acc_4), .en_reg(en_reg_4), .s_mar(s_mar_4), .s_acc(s_acc_4),
        .s_ir(s_ir_4), .s_iar(s_iar_4), .s_ram(s_ram_4), .s_tmp(s_tmp_4),
        .s_flags(s_flags_4), .s_reg(s_reg_4), .alu_op(alu_op_4), .step_err(step_err_4),
        .instr_cnt(instr_cnt_4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [0:5] step_vec(input int s);
        logic [0:5] b;
        b = '0;
        if (s >= 1 && s <= 6) b[s-1] = 1'b1;
        return b;
    endfunction

    task automatic tick(input logic [0:5] b, input logic e, input logic s);
        @(negedge clk);
        bos = b; wclke = e; wclks = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bos = '0; wclke = 1'b0; wclks = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One step: idle cycle, enable-only, enable+set, enable-only.
    task automatic do_step(input int s, input logic [7:0] xe, input logic [10:0] xs,
                           input logic [2:0] xo, input string nm);
        logic [0:5]  b;
        logic [21:0] exp;
        b = step_vec(s);
        tick(b, 1'b0, 1'b0);
        exp = '0;
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s S%0d idle: got %h want %h", nm, s, obs, exp);
        end
        tick(b, 1'b1, 1'b0);
        exp = {xo, xe, 11'b0};
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s S%0d enable: got %h want %h", nm, s, obs, exp);
        end
        tick(b, 1'b1, 1'b1);
        exp = {xo, xe, xs};
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s S%0d set: got %h want %h", nm, s, obs, exp);
        end
        tick(b, 1'b1, 1'b0);
        exp = {xo, xe, 11'b0};
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s S%0d tail: got %h want %h", nm, s, obs, exp);
        end
    endtask

    task automatic fetch(input string nm);
        do_step(1, E_S1, S_S1, 3'b000, nm);
        do_step(2, E_S2, S_S2, 3'b000, nm);
        do_step(3, E_S3, S_S3, 3'b000, nm);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({obs, step_err, instr_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_async: got %h/%b/%0d want 0", obs, step_err, instr_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if ({obs, step_err, instr_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_held: got %h/%b/%0d want 0", obs, step_err, instr_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu_add();
        ir = 8'h86; flags = 4'b0000;
        fetch("add");
        do_step(4, 8'b0000_0010, 11'b000_0010_0000, 3'b000, "add");
        do_step(5, 8'b0000_0100, 11'b010_0001_0000, 3'b000, "add");
        do_step(6, 8'b0001_0000, 11'b000_0000_0010, 3'b000, "add");
        checks++;
        if (instr_cnt !== 16'd0) begin
            fails++;
            $display("FAIL add_cnt_before: got %0d want 0", instr_cnt);
        end
        tick(step_vec(1), 1'b0, 1'b0);
        checks++;
        if (instr_cnt !== 16'd1 || step_err !== 1'b0) begin
            fails++;
            $display("FAIL add_cnt: got %0d err %b want 1 err 0", instr_cnt, step_err);
        end
    endtask

    task automatic test_cmp();
        ir = 8'hF1;
        fetch("cmp");
        do_step(4, 8'b0000_0100, 11'b000_0010_0000, 3'b000, "cmp");
        do_step(5, 8'b0000_1000, 11'b010_0001_0000, 3'b111, "cmp");
        do_step(6, 8'b0, 11'b0, 3'b000, "cmp");
    endtask

    task automatic test_jcaez();
        ir = 8'h52; flags = 4'b0010;
        fetch("jcaez_t");
        do_step(4, E_S1, S_S1, 3'b000, "jcaez_t");
        do_step(5, 8'b0001_0000, 11'b000_1000_0000, 3'b000, "jcaez_t");
        do_step(6, 8'b0010_0000, 11'b000_1000_0000, 3'b000, "jcaez_t");
        flags = 4'b0001;
        fetch("jcaez_n");
        do_step(4, E_S1, S_S1, 3'b000, "jcaez_n");
        do_step(5, 8'b0001_0000, 11'b000_1000_0000, 3'b000, "jcaez_n");
        do_step(6, 8'b0, 11'b0, 3'b000, "jcaez_n");
    endtask

    task automatic test_data();
        ir = 8'h2B; flags = 4'b0000;
        fetch("data");
        do_step(4, E_S1, S_S1, 3'b000, "data");
        do_step(5, 8'b0010_0000, 11'b000_0000_0001, 3'b000, "data");
        do_step(6, 8'b0001_0000, 11'b000_1000_0000, 3'b000, "data");
    endtask

    task automatic test_async_reset();
        logic [21:0] exp;
        ir = 8'h16;
        fetch("store");
        checks++;
        if (instr_cnt !== 16'd5) begin
            fails++;
            $display("FAIL store_cnt: got %0d want 5", instr_cnt);
        end
        do_step(4, 8'b0000_0100, 11'b100_0000_0000, 3'b000, "store");
        tick(step_vec(5), 1'b0, 1'b0);
        tick(step_vec(5), 1'b1, 1'b0);
        exp = {3'b000, 8'b0000_0010, 11'b0};
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL store_s5_en: got %h want %h", obs, exp);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({obs, step_err, instr_cnt} !== '0) begin
            fails++;
            $display("FAIL async_reset: got %h/%b/%0d want 0", obs, step_err, instr_cnt);
        end
        @(negedge clk);
        reset = 1'b0; bos = step_vec(3); wclke = 1'b1; wclks = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== 22'b0 || step_err !== 1'b1) begin
            fails++;
            $display("FAIL stray_s3: got %h err %b want 0 err 1", obs, step_err);
        end
    endtask

    task automatic test_step_errors();
        do_reset();
        checks++;
        if (step_err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear1: got %b want 0", step_err);
        end
        ir = 8'h30;
        do_step(1, E_S1, S_S1, 3'b000, "pre_bad");
        tick(6'b110000, 1'b1, 1'b1);
        checks++;
        if (obs !== 22'b0 || step_err !== 1'b1) begin
            fails++;
            $display("FAIL bad_onehot: got %h err %b want 0 err 1", obs, step_err);
        end
        do_reset();
        checks++;
        if (step_err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear2: got %b want 0", step_err);
        end
        do_step(1, E_S1, S_S1, 3'b000, "pre_skip");
        do_step(2, E_S2, S_S2, 3'b000, "pre_skip");
        tick(step_vec(4), 1'b0, 1'b0);
        checks++;
        if (step_err !== 1'b1) begin
            fails++;
            $display("FAIL skip_2_4: got %b want 1", step_err);
        end
        do_step(1, 8'b0, 11'b0, 3'b000, "restart_muted");
        checks++;
        if (step_err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: got %b want 1", step_err);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            for (int s = 1; s <= 6; s++) tick(step_vec(s), 1'b0, 1'b0);
        end
        checks++;
        if (instr_cnt_4 !== 4'd15 || instr_cnt !== 16'd15) begin
            fails++;
            $display("FAIL wrap_pre: got %0d/%0d want 15/15", instr_cnt_4, instr_cnt);
        end
        tick(step_vec(1), 1'b0, 1'b0);
        checks++;
        if (instr_cnt_4 !== 4'd0 || step_err_4 !== 1'b0) begin
            fails++;
            $display("FAIL wrap_cnt4: got %0d err %b want 0 err 0", instr_cnt_4, step_err_4);
        end
        checks++;
        if (instr_cnt !== 16'd16 || step_err !== 1'b0) begin
            fails++;
            $display("FAIL wrap_cnt16: got %0d err %b want 16 err 0", instr_cnt, step_err);
        end
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_cmp();
        test_jcaez();
        test_data();
        test_async_reset();
        test_step_errors();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
